// File: rtl/i2c_codec_target_pkg.sv
// Shared definitions for the I2C codec-control target.
// Contents: FSM state encoding, register reset defaults, frame bit positions,
// and a helper returning the reset default for a register index.
package i2c_codec_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ACK_A     = 3'd2,
    ST_BYTE1     = 3'd3,
    ST_ACK_1     = 3'd4,
    ST_BYTE2     = 3'd5,
    ST_ACK_2     = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // First data byte layout: {reg[6:0], data[8]}
  localparam int REG_MSB   = 7;
  localparam int REG_LSB   = 1;
  localparam int DATA8_BIT = 0;

  localparam int NUM_DEFAULTS = 10;
  localparam logic [8:0] REG_DEFAULTS [NUM_DEFAULTS] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  // Reset default for any index; indices without a listed default reset to 0.
  function automatic logic [8:0] reg_default(input int idx);
    logic [8:0] val;
    val = 9'h000;
    for (int i = 0; i < NUM_DEFAULTS; i++) begin
      if (idx == i) begin
        val = REG_DEFAULTS[i];
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/i2c_codec_target_bus_sync.sv
// Bus front end: 2-FF synchronizers on SCL/SDA followed by a registered edge
// stage. A pin change shows up on the event outputs 3 clk after it happens.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   scl_in,sda_in asynchronous bus levels
//   scl_rise/scl_fall  one-clk SCL edge pulses
//   start_det/stop_det one-clk START (SDA fall, SCL high) / STOP (SDA rise, SCL high)
//   sda_level     synchronized SDA, aligned with the event pulses
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_level
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_prev_r;
  logic       sda_prev_r;

  // Synchronize the bus lines and register edge/condition pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      sda_level  <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_prev_r <= scl_sync_r[1];
      sda_prev_r <= sda_sync_r[1];
      scl_rise   <= scl_sync_r[1] & ~scl_prev_r;
      scl_fall   <= ~scl_sync_r[1] & scl_prev_r;
      // SCL must be high both before and after the SDA change.
      start_det  <= scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
      stop_det   <= scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];
      sda_level  <= sda_sync_r[1];
    end
  end

endmodule

// File: rtl/i2c_codec_target.sv
// I2C write-only target modelling an audio codec control port.
// Frame: START, {ADDRESS,W}, {reg[6:0],data[8]}, {data[7:0]}, STOP.
// Ports:
//   clk, rst          system clock (>= 16x SCL), synchronous active-high reset
//   scl_in, sda_in    asynchronous bus levels
//   sda_oe            1 pulls SDA low (ACK)
//   wr_strobe         one-clk pulse per committed write
//   wr_reg, wr_data   index/data of the last committed write (held)
//   rd_addr, rd_data  combinational register-file read; 0 beyond NUM_REGS
//   busy              high between START and STOP
// Build option: define I2C_TGT_RESET_REG_EN to accept writes to index 15,
// which restore every register to its reset default.
// rd_data shows a committed write from the clk after the write edge.
module i2c_codec_target
  import i2c_codec_target_pkg::*;
#(
  parameter logic [6:0] ADDRESS  = 7'h1A,
  parameter int         NUM_REGS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_strobe,
  output logic [6:0] wr_reg,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy
);

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);
`ifdef I2C_TGT_RESET_REG_EN
  localparam logic [6:0] RESET_REG_IDX = 7'h0F;
`endif

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_level;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic [6:0] reg_idx_r;
  logic       data8_r;
  logic [8:0] regs_r [NUM_REGS];

  logic       collecting_s;
  logic       bit_in_s;
  logic       byte_done_s;
  logic       addr_match_s;
  logic       idx_accept_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_level (sda_level)
  );

  assign collecting_s = (state_r == ST_ADDR) || (state_r == ST_BYTE1) || (state_r == ST_BYTE2);
  assign bit_in_s     = collecting_s && scl_rise && (bit_cnt_r != 4'd8);
  // The ACK decision is made on the SCL fall that ends the 8th bit.
  assign byte_done_s  = scl_fall && (bit_cnt_r == 4'd8);
  assign addr_match_s = (shift_r[7:1] == ADDRESS) && (shift_r[0] == 1'b0);
`ifdef I2C_TGT_RESET_REG_EN
  assign idx_accept_s = (shift_r[REG_MSB:REG_LSB] < NUM_REGS_W) ||
                        (shift_r[REG_MSB:REG_LSB] == RESET_REG_IDX);
`else
  assign idx_accept_s = (shift_r[REG_MSB:REG_LSB] < NUM_REGS_W);
`endif

  // Protocol FSM, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      reg_idx_r <= 7'h00;
      data8_r   <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_reg    <= 7'h00;
      wr_data   <= 9'h000;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= reg_default(i);
      end
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (start_det) begin
        // Also covers repeated START: any partial frame is dropped.
        state_r   <= ST_ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else begin
        if (bit_in_s) begin
          shift_r   <= {shift_r[6:0], sda_level};
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
        case (state_r)
          ST_ADDR: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
              if (addr_match_s) begin
                sda_oe  <= 1'b1;
                state_r <= ST_ACK_A;
              end else begin
                state_r <= ST_WAIT_STOP;
              end
            end
          end
          ST_BYTE1: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
              reg_idx_r <= shift_r[REG_MSB:REG_LSB];
              data8_r   <= shift_r[DATA8_BIT];
              if (idx_accept_s) begin
                sda_oe  <= 1'b1;
                state_r <= ST_ACK_1;
              end else begin
                state_r <= ST_WAIT_STOP;
              end
            end
          end
          ST_BYTE2: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
              sda_oe    <= 1'b1;
              wr_strobe <= 1'b1;
              wr_reg    <= reg_idx_r;
              wr_data   <= {data8_r, shift_r};
              state_r   <= ST_ACK_2;
`ifdef I2C_TGT_RESET_REG_EN
              if (reg_idx_r == RESET_REG_IDX) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  regs_r[i] <= reg_default(i);
                end
              end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (reg_idx_r == 7'(i)) regs_r[i] <= {data8_r, shift_r};
                end
              end
`else
              for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_idx_r == 7'(i)) regs_r[i] <= {data8_r, shift_r};
              end
`endif
            end
          end
          ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
            if (scl_fall) begin
              sda_oe    <= 1'b0;
              bit_cnt_r <= 4'd0;
              state_r   <= (state_r == ST_ACK_A) ? ST_BYTE1 :
                           (state_r == ST_ACK_1) ? ST_BYTE2 : ST_WAIT_STOP;
            end
          end
          ST_IDLE, ST_WAIT_STOP: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= ST_IDLE;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    rd_data = 9'h000;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data = (rd_addr == 4'(i)) ? regs_r[i] : rd_data;
    end
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Self-checking bench for i2c_codec_target: a bit-banged I2C initiator drives
// table-driven frames; expected writes go through a scoreboard queue that a
// strobe monitor drains, and a bench-side register model checks the read port.
module tb_i2c_codec_target;

  localparam int Q = 8;  // clk per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_drv;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_strobe;
  logic [6:0] wr_reg;
  logic [8:0] wr_data;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [6:0] r;
    logic [8:0] d;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    string      name;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         nbytes;
    logic [2:0] exp_ack;   // bit k = ACK expected on byte k
    logic       exp_wr;
    logic [6:0] exp_reg;
    logic [8:0] exp_data;
  } vec_t;

  vec_t       vecs [12];
  logic [8:0] model [16];
  logic       strobe_prev = 1'b0;

  // Open-drain bus: the line is low if either side pulls it.
  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_codec_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int nb, input logic [2:0] ack,
                              input logic wr, input logic [6:0] r, input logic [8:0] d);
    vec_t v;
    v.name = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.nbytes = nb;
    v.exp_ack = ack; v.exp_wr = wr; v.exp_reg = r; v.exp_data = d;
    return v;
  endfunction

  task automatic model_defaults();
    for (int i = 0; i < 16; i++) model[i] = 9'h000;
    model[0] = 9'h097; model[1] = 9'h097; model[2] = 9'h079; model[3] = 9'h079;
    model[4] = 9'h00A; model[5] = 9'h008; model[6] = 9'h09F; model[7] = 9'h00A;
  endtask

  // Strobe monitor: each strobe must be a single clk and match the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      strobe_prev <= 1'b0;
    end else begin
      if (wr_strobe) begin
        check("strobe_expected", exp_q.size() != 0, 1);
        check("strobe_width", strobe_prev, 0);
        if (exp_q.size() != 0) begin
          check("wr_reg", wr_reg, exp_q[0].r);
          check("wr_data", wr_data, exp_q[0].d);
          void'(exp_q.pop_front());
        end
      end
      strobe_prev <= wr_strobe;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wclk(Q);
    scl = 1'b1;     wclk(Q);
    sda_drv = 1'b0; wclk(Q);
    scl = 1'b0;     wclk(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wclk(Q);
    scl = 1'b1;     wclk(Q);
    sda_drv = 1'b1; wclk(Q);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = v[i]; wclk(Q);
      scl = 1'b1;     wclk(2 * Q);
      scl = 1'b0;     wclk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    send_bits(v, 8);
    sda_drv = 1'b1; wclk(Q);
    scl = 1'b1;     wclk(Q);
    ack = (sda_line == 1'b0);
    wclk(Q);
    scl = 1'b0;     wclk(Q);
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("%s rd_data[%0d]", tag, a), rd_data, model[a]);
    end
    wclk(1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] bytes [3];
    logic       ack;
    bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
    if (v.exp_wr) begin
      exp_q.push_back({v.exp_reg, v.exp_data});
      if (v.exp_reg == 7'h0F) model_defaults();
      else model[v.exp_reg] = v.exp_data;
    end
    bus_start();
    check({v.name, " busy_after_start"}, busy, 1);
    for (int k = 0; k < v.nbytes; k++) begin
      send_byte(bytes[k], ack);
      check($sformatf("%s ack%0d", v.name, k), ack, v.exp_ack[k]);
    end
    bus_stop();
    wclk(6);
    check({v.name, " busy_after_stop"}, busy, 0);
    check({v.name, " sda_oe_idle"}, sda_oe, 0);
    check({v.name, " pending_writes"}, exp_q.size(), 0);
    check_regs(v.name);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    vec_t v;

    vecs[0]  = mk("partial",  8'h34, 8'h0C, 8'h00, 2, 3'b011, 1'b0, 7'd0, 9'h000);
    vecs[1]  = mk("wr_reg6",  8'h34, 8'h0C, 8'h10, 3, 3'b111, 1'b1, 7'd6, 9'h010);
    vecs[2]  = mk("read_rw",  8'h35, 8'h0C, 8'h10, 3, 3'b000, 1'b0, 7'd0, 9'h000);
    vecs[3]  = mk("bad_addr", 8'h36, 8'h0C, 8'h10, 3, 3'b000, 1'b0, 7'd0, 9'h000);
    vecs[4]  = mk("reg12",    8'h34, 8'h18, 8'h55, 3, 3'b001, 1'b0, 7'd0, 9'h000);
    vecs[5]  = mk("wr_reg4",  8'h34, 8'h09, 8'hFF, 3, 3'b111, 1'b1, 7'd4, 9'h1FF);
    vecs[6]  = mk("wr_reg9",  8'h34, 8'h13, 8'hAB, 3, 3'b111, 1'b1, 7'd9, 9'h1AB);
    vecs[7]  = mk("wr_reg0",  8'h34, 8'h00, 8'h00, 3, 3'b111, 1'b1, 7'd0, 9'h000);
    vecs[8]  = mk("reg10",    8'h34, 8'h14, 8'h3C, 3, 3'b001, 1'b0, 7'd0, 9'h000);
`ifdef I2C_TGT_RESET_REG_EN
    vecs[9]  = mk("reg15",    8'h34, 8'h1E, 8'h00, 3, 3'b111, 1'b1, 7'd15, 9'h000);
`else
    vecs[9]  = mk("reg15",    8'h34, 8'h1E, 8'h00, 3, 3'b001, 1'b0, 7'd0, 9'h000);
`endif
    vecs[10] = mk("wr_reg1",  8'h34, 8'h03, 8'h5A, 3, 3'b111, 1'b1, 7'd1, 9'h15A);
    vecs[11] = mk("addr_00",  8'h00, 8'h03, 8'h5A, 3, 3'b000, 1'b0, 7'd0, 9'h000);

    rst = 1'b1; scl = 1'b1; sda_drv = 1'b1; rd_addr = 4'd0;
    model_defaults();
    wclk(4);
    rst = 1'b0;
    wclk(2);
    check("reset sda_oe", sda_oe, 0);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset wr_reg", wr_reg, 0);
    check("reset wr_data", wr_data, 0);
    check("reset busy", busy, 0);
    check_regs("reset");

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset pulsed in the middle of BYTE2 of a reg 4 write (SCL low).
    bus_start();
    send_byte(8'h34, ack); check("rst_mid ack0", ack, 1);
    send_byte(8'h09, ack); check("rst_mid ack1", ack, 1);
    send_bits(8'h55, 4);
    rst = 1'b1; wclk(1); rst = 1'b0; wclk(2);
    model_defaults();
    check("rst_mid sda_oe", sda_oe, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid wr_reg", wr_reg, 0);
    check("rst_mid wr_data", wr_data, 0);
    check_regs("rst_mid");
    bus_stop();
    wclk(Q);
    v = mk("after_rst", 8'h34, 8'h09, 8'h55, 3, 3'b111, 1'b1, 7'd4, 9'h155);
    run_vec(v);

    // Repeated START during BYTE2 drops the reg 6 frame; the new frame writes reg 5.
    bus_start();
    send_byte(8'h34, ack); check("rs ack0", ack, 1);
    send_byte(8'h0C, ack); check("rs ack1", ack, 1);
    send_bits(8'hAA, 3);
    v = mk("rep_start", 8'h34, 8'h0A, 8'h22, 3, 3'b111, 1'b1, 7'd5, 9'h022);
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_codec_target.md
Name: i2c_codec_target

Overview:
- I2C target (responder) modelling the audio codec's write-only control port: 7-bit device address, two-byte frames {reg[6:0], data[8]}, {data[7:0]}.
- Holds a 9-bit register file the initiator writes; exposes each write as a strobe plus a combinational read port.
- Sits opposite the existing audio-init I2C initiator, both in simulation benches (codec stand-in) and in FPGA loopback builds.

Parameters:
- ADDRESS, 7'h1A, device address this target answers to.
- NUM_REGS, 10, number of implemented registers (indices 0..NUM_REGS-1).

Ports:
- clk  in  1  system clock; must be at least 16x SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL line level (asynchronous).
- sda_in  in  1  SDA line level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (ACK); 0 = release.
- wr_strobe  out  1  one-clk pulse when a register write commits.
- wr_reg  out  7  register index of the committed write (valid with wr_strobe, then held).
- wr_data  out  9  data of the committed write (held).
- rd_addr  in  4  register-file read index.
- rd_data  out  9  combinational contents of register rd_addr; 0 if rd_addr >= NUM_REGS.
- busy  out  1  high from START until STOP or abort to IDLE.

Behaviour:
- Reset values: sda_oe=0, wr_strobe=0, wr_reg=0, wr_data=0, busy=0, state=IDLE, bit counter=0, synchronizers=1.
- Register file reset defaults (0..9): 097,097,079,079,00A,008,09F,00A,000,000 (hex).
- scl_in and sda_in each pass through a 2-FF synchronizer, then a 1-FF edge detector. A pin change is visible to the FSM 3 clk later.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high.
- Data bits are sampled on SCL rise, MSB first. sda_oe changes only on SCL fall.
- FSM states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP.
- IDLE: a START goes to ADDR with the bit counter cleared.
- ADDR: collect 8 bits. On the SCL fall after bit 8:
  - if addr==ADDRESS and R/W=0: set sda_oe=1, go to ACK_A;
  - otherwise leave sda_oe=0 (NACK) and go to WAIT_STOP.
- ACK_A: on the next SCL fall, set sda_oe=0 and go to BYTE1.
- BYTE1: collect 8 bits. On the SCL fall after bit 8:
  - if reg index < NUM_REGS: ACK, go to ACK_1;
  - otherwise NACK, go to WAIT_STOP.
- ACK_1: release SDA on the next SCL fall, go to BYTE2.
- BYTE2: collect 8 bits. On the SCL fall after bit 8:
  - ACK;
  - write the register and load wr_reg/wr_data;
  - pulse wr_strobe for exactly 1 clk;
  - go to ACK_2.
- ACK_2: release SDA on the next SCL fall, go to WAIT_STOP.
- WAIT_STOP: any further bytes are ignored (sda_oe stays 0, which reads as NACK).
- STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial frame is discarded with no write.
- Repeated START in any non-IDLE state: go to ADDR, sda_oe=0, partial frame discarded.
- START/STOP take priority over a coincident SCL edge in the same clk.
- rst mid-transfer: immediate return to reset values and register defaults. The target ignores the bus until the next START.
- rd_data reads the current contents, including a write committed in the same clk (write-first bypass not required; a 1-clk lag is acceptable and documented).

Optional Feature:
- Macro: I2C_TGT_RESET_REG_EN.
- Defined: index 15 (0x0F) is accepted as a write even though it is >= NUM_REGS. Committing it restores all registers to defaults and pulses wr_strobe with wr_reg=0x0F; the data value is ignored.
- Undefined: index 15 follows the normal rule (NACK on BYTE1, no strobe).

Decomposition:
- Shared package: state encoding, the register-default constant array, and frame bit positions (REG_MSB/REG_LSB, DATA8 bit).
- One sub-module: i2c_bus_sync, the 2-FF synchronizers plus edge/START/STOP detection. Outputs scl_rise, scl_fall, start_det, stop_det.

Test Plan:
- Write reg 6 = 0x010: bytes 0x34, 0x0C, 0x10 plus STOP -> three ACKs, one wr_strobe, wr_reg=6, wr_data=0x010, rd_addr=6 gives 0x010.
- Address byte 0x35 (R/W=1) -> NACK at ACK_A, no strobe, busy drops on STOP.
- Address byte 0x36 -> NACK, sda_oe never asserted, all registers unchanged.
- Bytes 0x34, 0x0C, then STOP -> two ACKs, no strobe, reg 6 still 0x09F.
- Byte1 0x18 (reg 12) -> NACK on byte1, no strobe. With I2C_TGT_RESET_REG_EN, byte1 0x1E then 0x00 after a prior write -> strobe, all registers back to defaults.
- rst pulsed during BYTE2 of a reg 4 write -> sda_oe=0, busy=0, reg 4 = 0x00A. The next full frame writes correctly.
